// File: rtl/delay_correlator_if.sv
// ----------------------------------------------------------------------------
// delay_correlator_if
//
// Purpose:
//   Minimal AXI-Stream bundle (valid / ready / data) shared by the three
//   streams of the delay correlator: the live sample input, the delayed
//   sample input and the correlation output.
//
// Signals:
//   tvalid  producer -> consumer, beat available
//   tready  consumer -> producer, beat accepted when tvalid & tready
//   tdata   producer -> consumer, WIDTH-bit payload
//
// Modports:
//   master  drives tvalid/tdata, observes tready
//   slave   observes tvalid/tdata, drives tready
// ----------------------------------------------------------------------------
interface delay_correlator_if #(
    parameter int WIDTH = 32
) ();
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/delay_correlator.sv
// ----------------------------------------------------------------------------
// delay_correlator
//
// Purpose:
//   Joins the live sample stream x and its delayed copy d pairwise, forms the
//   per-sample product x[n] * conj(d[n]) (each component floored by
//   PROD_SHIFT) and emits the sliding sum of the last WINDOW products.  The
//   complex sum is the metric used for short-training-field detection and
//   coarse CFO estimation downstream.
//
// Parameters:
//   WINDOW                  number of products summed, power of two, 2..64
//   PROD_SHIFT              arithmetic right shift applied to each product
//   C_S00_AXIS_TDATA_WIDTH  input sample width, [31:16] = I, [15:0] = Q
//   C_M00_AXIS_TDATA_WIDTH  output width, [63:32] = real sum, [31:0] = imag
//
// Ports:
//   s00_axis_aclk    single clock, all logic on the rising edge
//   s00_axis_areset  synchronous active-high reset
//   s00_axis         slave stream, live sample x
//   s01_axis         slave stream, delayed sample d
//   m00_axis         master stream, registered correlation sum
// ----------------------------------------------------------------------------
module delay_correlator #(
    parameter int WINDOW                 = 16,
    parameter int PROD_SHIFT             = 15,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64
) (
    input  logic                      s00_axis_aclk,
    input  logic                      s00_axis_areset,
    delay_correlator_if.slave         s00_axis,
    delay_correlator_if.slave         s01_axis,
    delay_correlator_if.master        m00_axis
);

    localparam int                PTR_W = $clog2(WINDOW);
    localparam int                CNT_W = $clog2(WINDOW) + 1;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(WINDOW);

    // Handshake / global advance
    logic en;
    logic fire;

    // Stage 1: registered product
    logic               v1_q, v1_d;
    logic signed [31:0] p_re_q, p_re_d;
    logic signed [31:0] p_im_q, p_im_d;

    // Stage 1 combinational operands
    logic signed [15:0] xi, xq, di, dq;
    logic signed [31:0] prod_ii, prod_qq, prod_qi, prod_iq;
    logic signed [32:0] sum_re, sum_im;
    logic signed [32:0] sh_re, sh_im;

    // Stage 2: window history, accumulator, fill count, output valid
    logic signed [31:0] hist_re_q [WINDOW];
    logic signed [31:0] hist_re_d [WINDOW];
    logic signed [31:0] hist_im_q [WINDOW];
    logic signed [31:0] hist_im_d [WINDOW];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic signed [31:0] acc_re_q, acc_re_d;
    logic signed [31:0] acc_im_q, acc_im_d;
    logic               m_valid_q, m_valid_d;
    logic               full;
    logic signed [31:0] old_re, old_im;

    // The whole pipeline advances only when the output register can take a
    // new value; a stalled output therefore freezes every stage, and both
    // inputs are accepted together or not at all.
    assign en   = ~m_valid_q | m00_axis.tready;
    assign fire = en & s00_axis.tvalid & s01_axis.tvalid;

    assign s00_axis.tready = en & s01_axis.tvalid;
    assign s01_axis.tready = en & s00_axis.tvalid;

    assign m00_axis.tvalid = m_valid_q;
    assign m00_axis.tdata  = C_M00_AXIS_TDATA_WIDTH'({acc_re_q, acc_im_q});

    // Full-precision complex multiply by the conjugate of the delayed sample.
    // The 33-bit sums are floored by the arithmetic shift; the result always
    // fits in 32 bits, so truncation only drops redundant sign bits.
    always_comb begin
        xi = s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1 -: 16];
        xq = s00_axis.tdata[15:0];
        di = s01_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1 -: 16];
        dq = s01_axis.tdata[15:0];

        prod_ii = 32'(xi) * 32'(di);
        prod_qq = 32'(xq) * 32'(dq);
        prod_qi = 32'(xq) * 32'(di);
        prod_iq = 32'(xi) * 32'(dq);

        sum_re = 33'(prod_ii) + 33'(prod_qq);
        sum_im = 33'(prod_qi) - 33'(prod_iq);

        sh_re = sum_re >>> PROD_SHIFT;
        sh_im = sum_im >>> PROD_SHIFT;

        v1_d   = v1_q;
        p_re_d = p_re_q;
        p_im_d = p_im_q;
        if (en) begin
            v1_d   = fire;
            p_re_d = sh_re[31:0];
            p_im_d = sh_im[31:0];
        end
    end

    // Sliding-window sum kept as a running accumulator: add the newest product
    // and subtract the one it overwrites in the circular history.  Until the
    // history has been filled once, nothing is subtracted.  Bubbles (v1 = 0)
    // leave the history untouched so the window counts pairs, not cycles.
    always_comb begin
        hist_re_d = hist_re_q;
        hist_im_d = hist_im_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        m_valid_d = m_valid_q;

        full   = (fill_q == FULL);
        old_re = full ? hist_re_q[wr_ptr_q] : 32'sd0;
        old_im = full ? hist_im_q[wr_ptr_q] : 32'sd0;

        if (en) begin
            m_valid_d = 1'b0;
            if (v1_q) begin
                hist_re_d[wr_ptr_q] = p_re_q;
                hist_im_d[wr_ptr_q] = p_im_q;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                acc_re_d  = acc_re_q + p_re_q - old_re;
                acc_im_d  = acc_im_q + p_im_q - old_im;
                fill_d    = full ? fill_q : fill_q + CNT_W'(1);
                m_valid_d = (fill_d == FULL);
            end
        end
    end

    // State registers; reset takes priority over any simultaneous fire.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            v1_q      <= 1'b0;
            p_re_q    <= '0;
            p_im_q    <= '0;
            for (int i = 0; i < WINDOW; i++) begin
                hist_re_q[i] <= '0;
                hist_im_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            p_re_q    <= p_re_d;
            p_im_q    <= p_im_d;
            hist_re_q <= hist_re_d;
            hist_im_q <= hist_im_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule

// File: doc/delay_correlator.md
# delay_correlator

Consumes the live sample stream and its SAMPLES-delayed copy, which the delay line produces on its output. Joins the two AXI-Stream inputs pairwise and forms the per-sample product x[n]·conj(x[n−D]). Emits the sliding sum of the last WINDOW products as a complex metric for short-training-field detection and coarse CFO estimation in the CSI extractor. Sits directly downstream of the delay line and upstream of the packet detector.

## Interface
- WINDOW, 16, number of products summed; power of two, 2..64
- PROD_SHIFT, 15, arithmetic right shift applied to each product component before accumulation
- C_S00_AXIS_TDATA_WIDTH, 32, input sample width; [31:16] = I, [15:0] = Q, both signed two's complement
- C_M00_AXIS_TDATA_WIDTH, 64, output width; [63:32] = real sum, [31:0] = imag sum, both signed

Ports:
- s00_axis_aclk  in  1  single clock, all logic on rising edge
- s00_axis_areset  in  1  reset, synchronous, active-high
- s00_axis_tvalid / s00_axis_tready / s00_axis_tdata  in/out/in  1/1/32  live sample x
- s01_axis_tvalid / s01_axis_tready / s01_axis_tdata  in/out/in  1/1/32  delayed sample d
- m00_axis_tvalid / m00_axis_tready / m00_axis_tdata  out/in/out  1/1/64  correlation sum

## Operation
- Global advance: en = ~m00_axis_tvalid | m00_axis_tready. When en = 0, every register holds.
- Join rule:
  - s00_axis_tready = en & s01_axis_tvalid; s01_axis_tready = en & s00_axis_tvalid.
  - Fire = en & s00_axis_tvalid & s01_axis_tvalid; both beats are consumed in the same cycle, never one alone.
- Stage 1 (registered on en):
  - v1 <= fire.
  - p_re = (xi·di + xq·dq) >>> PROD_SHIFT; p_im = (xq·di − xi·dq) >>> PROD_SHIFT.
  - Products are full precision: 16×16 → 32 bits, sum 33 bits. The shift floors toward −inf. Results are sign-extended to 32 bits.
- Stage 2 (on en & v1):
  - Push (p_re, p_im) into a WINDOW-deep history.
  - acc <= acc + p_new − p_oldest, where p_oldest is 0 while the history is not yet full.
  - fill count increments, saturating at WINDOW.
- Output valid: on en, m00_axis_tvalid <= v1 & (fill count after this push == WINDOW). The first WINDOW−1 products are suppressed (warm-up).
  - On en with v1 = 0, m00_axis_tvalid <= 0.
- m00_axis_tdata = {acc_re, acc_im}, registered. With the defaults no overflow is possible (18-bit terms + log2(64) < 32 bits); the sum is exact modulo the per-product floor.
- Reset: clears v1, history, acc, fill count, m00_axis_tvalid and m00_axis_tdata. Reset wins over any simultaneous fire. After a mid-stream reset, a full new WINDOW of pairs is required before the next valid output.

## Timing
- Reset values: m00_axis_tvalid = 0, m00_axis_tdata = 0. s00_axis_tready and s01_axis_tready are combinational (each 1 only if en and the other input is valid).
- Latency: a pair firing in cycle t appears on m00_axis_tdata, with m00_axis_tvalid, in cycle t+2.
- Throughput: one pair per cycle with continuous valids and m00_axis_tready held at 1.
- Backpressure:
  - m00_axis_tready = 0 with m00_axis_tvalid = 1 freezes the whole pipeline; both input treadys drop in the same cycle.
  - No beat is lost or duplicated; the output holds its data stable.
- Input imbalance: if only one input is valid, nothing is consumed and the pipeline bubbles (v1 = 0).
- Bubbles:
  - Do not disturb the history; the window counts pairs, not cycles.
  - A pair that fires during a stall is impossible by construction.

## Test plan
- Warm-up and steady state:
  - Stimulus: x = d = (4096, 0) continuously, tready = 1.
  - Response: first valid output appears 2 cycles after the 16th fire, value {8192, 0}; all subsequent outputs are {8192, 0}.
- Imaginary and sign:
  - Stimulus: x = (0, 4096), d = (4096, 0) for 16 pairs.
  - Response: {0, 8192}.
  - Then switch to x = (−4096, 0): the real part walks 0x0..., i.e. real = −512·k, and the imag part decreases by 512 per output until {−8192, 0} is reached after 16 more pairs.
- Floor rounding:
  - Stimulus: x = (−1, 0), d = (1, 0) for 16 pairs → {−16, 0}.
  - Stimulus: x = d = (1, 0) for 16 pairs → {0, 0}.
- Join and backpressure:
  - Stimulus: randomize both input valids and m00_axis_tready, with 200 pairs of known data.
  - Response: output sequence identical to the no-stall golden model; tdata stable while stalled; no fire with only one input valid.
- Reset mid-stream:
  - Stimulus: assert s00_axis_areset for 1 cycle after 20 pairs.
  - Response: m00_axis_tvalid = 0 the next cycle; no output until 16 new pairs have fired; the first output equals the sum of the new pairs only.
- Max magnitude:
  - Stimulus: x = d = (−32768, −32768) for 16 pairs.
  - Response: real = 16·65536 = 1048576, imag = 0, with no wrap.
